// File: rtl/sqr_seq_arbiter.sv
// Shared incremental perfect-square engine for NUM_REQ requesters. Each requester
// keeps its own sequence context; a round-robin grant feeds a registered valid/ready port.

module sqr_ctx #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] sq,
  output logic         wrap
);
  logic [W-1:0] odd;
  logic [W:0]   sum;

  assign sum  = {1'b0, sq} + {1'b0, odd};
  assign wrap = sum[W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq  <= W'(1);
      odd <= W'(3);
    end else if (clr || (step && wrap)) begin
      // the largest representable square restarts the stream, same as a clear
      sq  <= W'(1);
      odd <= W'(3);
    end else if (step) begin
      sq  <= sum[W-1:0];
      odd <= odd + W'(2);
    end
  end
endmodule

module sqr_seq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 32,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] clr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               sqr_valid_o,
  output logic [W-1:0]       sqr_o,
  output logic [IDW-1:0]     sqr_id_o,
  output logic               last_o,
  input  logic               out_ready_i
);
  logic [NUM_REQ-1:0][W-1:0] sq_all;
  logic [NUM_REQ-1:0]        wrap_all;
  logic [NUM_REQ-1:0]        elig;
  logic [NUM_REQ-1:0]        gnt;
  logic [IDW-1:0]            ptr, idx, gnt_idx;
  logic                      found, adv;
  logic [1:0]                vld_pipe;

  assign adv  = !vld_pipe[1] || out_ready_i;
  assign elig = req_i & ~clr_i;

  // round-robin search from ptr; a clear masks its requester for the cycle
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = IDW'((int'(ptr) + o) % NUM_REQ);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = '0;
    if (found && adv && reset_n) gnt[gnt_idx] = 1'b1;
  end

  assign gnt_o       = gnt;
  assign vld_pipe[0] = |gnt;
  assign sqr_valid_o = vld_pipe[1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ctx
    sqr_ctx #(.W(W)) u_ctx (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_i[i]),
      .step    (gnt[i]),
      .sq      (sq_all[i]),
      .wrap    (wrap_all[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[1] <= 1'b0;
      sqr_o       <= '0;
      sqr_id_o    <= '0;
      last_o      <= 1'b0;
      ptr         <= '0;
    end else if (adv) begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        sqr_o    <= sq_all[gnt_idx];
        sqr_id_o <= gnt_idx;
        last_o   <= wrap_all[gnt_idx];
        ptr      <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sqr_seq_arbiter.sv
// Scoreboarded bench for sqr_seq_arbiter (4 requesters, 8-bit squares so the wrap is reachable).

module tb_sqr_seq_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req_i, clr_i, gnt_o;
  logic         sqr_valid_o, last_o, out_ready_i;
  logic [W-1:0] sqr_o;
  logic [1:0]   sqr_id_o;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sq;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  sqr_seq_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .clr_i       (clr_i),
    .gnt_o       (gnt_o),
    .sqr_valid_o (sqr_valid_o),
    .sqr_o       (sqr_o),
    .sqr_id_o    (sqr_id_o),
    .last_o      (last_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every accepted response must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && sqr_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", {24'd0, sqr_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", {30'd0, sqr_id_o}, {30'd0, e.id});
        chk("rsp_sq", {24'd0, sqr_o}, {24'd0, e.sq});
        chk("rsp_last", {31'd0, last_o}, {31'd0, e.last});
      end
    end
  end

  function automatic logic [1:0] oh2id(input logic [N-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // one cycle of stimulus; a non-zero expected grant queues the expected response
  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] clr, input logic rdy,
                     input logic [N-1:0] eg, input logic [W-1:0] esq, input logic elast);
    exp_t e;
    @(posedge clk); #1;
    req_i = req; clr_i = clr; out_ready_i = rdy;
    if (eg != '0) begin
      e.id = oh2id(eg); e.sq = esq; e.last = elast;
      q.push_back(e);
    end
    @(negedge clk);
    chk("gnt", {28'd0, gnt_o}, {28'd0, eg});
  endtask

  task automatic stall(input logic [N-1:0] req, input logic [N-1:0] clr, input logic [W-1:0] esq);
    @(posedge clk); #1;
    req_i = req; clr_i = clr; out_ready_i = 1'b0;
    @(negedge clk);
    chk("stall_gnt", {28'd0, gnt_o}, 32'd0);
    chk("stall_valid", {31'd0, sqr_valid_o}, 32'd1);
    chk("stall_sq", {24'd0, sqr_o}, {24'd0, esq});
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'd0, sqr_valid_o}, 32'd0);
    chk("rst_sq", {24'd0, sqr_o}, 32'd0);
    chk("rst_id", {30'd0, sqr_id_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_i = 4'b1111; clr_i = '0; out_ready_i = 1'b1;
    #12;
    check_reset_outputs();
    @(negedge clk); req_i = '0; reset_n = 1'b1;

    // single requester streams at full rate
    for (int n = 1; n <= 6; n++) cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, W'(n * n), 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, '0, 1'b0);

    // reset between phases: restart pointer and contexts
    @(posedge clk); #2; reset_n = 1'b0; req_i = 4'b1111;
    #1; check_reset_outputs(); q.delete();
    @(negedge clk); reset_n = 1'b1; req_i = '0;

    // all four requesting: rotation 0,1,2,3,0,1,2
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0001, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0010, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0100, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b1000, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0001, 8'd4, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0010, 8'd4, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0100, 8'd4, 1'b0);

    // requester 2 cleared while requesting: masked that cycle, then restarts
    cyc(4'b0100, 4'b0100, 1'b1, 4'b0000, '0, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 8'd1, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, 8'd4, 1'b0);

    // backpressure on response 9; clear requester 1 during the stall
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 8'd9, 1'b0);
    stall(4'b0001, 4'b0000, 8'd9);
    stall(4'b0001, 4'b0010, 8'd9);
    stall(4'b0001, 4'b0000, 8'd9);
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 8'd16, 1'b0);
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, 8'd1, 1'b0);

    // requester 0 runs to the 8-bit wrap: 225 is last, then back to 1
    for (int n = 5; n <= 15; n++) cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, W'(n * n), n == 15);
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 8'd1, 1'b0);
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 8'd4, 1'b0);

    // mid-stream async reset with a response in the output register
    cyc(4'b0011, 4'b0000, 1'b1, 4'b0010, 8'd4, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_valid", {31'd0, sqr_valid_o}, 32'd1);
    reset_n = 1'b0;
    #1; check_reset_outputs(); q.delete();
    @(negedge clk); reset_n = 1'b1; req_i = '0;
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0001, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0010, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0100, 8'd1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b1000, 8'd1, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, '0, 1'b0);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    chk("drain", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sqr_seq_arbiter.md
Name: sqr_seq_arbiter

Overview:
- Shares one incremental perfect-square engine (square += odd, odd += 2) between NUM_REQ requesters.
- Keeps a private sequence context per requester, so each requester sees its own stream 1, 4, 9, 16, … independently of the others.
- Round-robin arbitration chooses one requester per cycle; a registered response port with valid/ready backpressure returns the square.
- Sits between the square-sequence clients and the downstream consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2 to 16).
- W, 32, square and odd-increment width in bits.
- IDW, $clog2(NUM_REQ), requester ID width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- req_i  input  NUM_REQ  per-requester request for its next square; level held until granted.
- clr_i  input  NUM_REQ  per-requester sequence restart; single-cycle.
- gnt_o  output  NUM_REQ  one-hot grant; combinational, same cycle as req_i.
- sqr_valid_o  output  1  response valid.
- sqr_o  output  W  granted requester's square.
- sqr_id_o  output  IDW  index of the requester that owns sqr_o.
- last_o  output  1  sqr_o is the largest square representable in W bits; that context has restarted.
- out_ready_i  input  1  downstream accepts the response when sqr_valid_o and out_ready_i are both high.

Behaviour:
- Context i holds sq[i] (W bits) and odd[i] (W bits).
  - Reset/cleared value: sq = 1, odd = 3.
- Arbitration is enabled (adv) when sqr_valid_o = 0 or out_ready_i = 1.
- Eligible requesters: req_i[i] = 1 and clr_i[i] = 0. A requester being cleared is masked for that cycle.
- Round robin: search starts at ptr and wraps modulo NUM_REQ.
  - gnt_o is the first eligible index found, or all-zero if none is eligible or adv = 0.
  - On a grant to k, ptr becomes (k+1) mod NUM_REQ.
  - Reset value of ptr is 0.
- On a clock edge with a grant to k:
  - sqr_o <= sq[k], sqr_id_o <= k, sqr_valid_o <= 1. Latency is one cycle from grant to valid.
  - Sum = sq[k] + odd[k], computed at W+1 bits.
  - If there is no carry out: sq[k] <= sum[W-1:0], odd[k] <= odd[k] + 2; last_o <= 0.
  - If there is a carry out: sq[k] <= 1, odd[k] <= 3; last_o <= 1.
- With adv = 1 and no grant: sqr_valid_o <= 0. sqr_o, sqr_id_o and last_o hold their values.
- With adv = 0 (sqr_valid_o = 1 and out_ready_i = 0): all response outputs hold stable, gnt_o = 0, and no context changes except clears.
- clr_i[i] = 1 at an edge restarts context i to 1/3 on that edge, even during backpressure.
  - It does not affect a response already in the output register.
  - Clearing requester i does not move ptr.
- Requests from different requesters in the same cycle: only one is granted. Losers stay pending because req_i is held.
- Response ID and value always belong to the same grant; back-to-back grants are allowed at full rate when out_ready_i = 1.
- Asynchronous reset (reset_n = 0), including mid-stream:
  - All contexts go to 1/3 and ptr goes to 0.
  - sqr_valid_o = 0, sqr_o = 0, sqr_id_o = 0, last_o = 0.
  - gnt_o is forced to 0 while reset_n = 0.
  - Any in-flight response is dropped.
- NUM_REQ = 1 degenerates to a plain gated square generator; ptr stays at 0.

Test Plan:
- Only req_i[0] high, out_ready_i = 1, for 6 cycles: sqr_o = 1, 4, 9, 16, 25, 36 on consecutive cycles; sqr_id_o = 0; gnt_o = 4'b0001 each cycle.
- req_i = 4'b1111 held, out_ready_i = 1: grants go 0, 1, 2, 3, 0, 1; responses are (id, sq) = (0,1), (1,1), (2,1), (3,1), (0,4), (1,4).
- Requester 2 has received 1 and 4; pulse clr_i[2] while req_i[2] = 1: no grant to 2 that cycle; next grant to 2 returns 1, then 4.
- Response (0,9) is valid; drop out_ready_i for 3 cycles: sqr_o stays 9, sqr_valid_o stays 1, gnt_o = 0. Raise out_ready_i: the next response appears one cycle later.
- W = 8, requester 0 streams continuously: …, 196, 225 with last_o = 1 on 225 (225 + 31 = 256 carries out); the next response is 1 with last_o = 0.
- Assert reset_n = 0 mid-stream with a response valid: sqr_valid_o drops to 0 immediately (asynchronously). After release: ptr = 0, and every requester restarts at 1.
